// File: rtl/gru_lstm_cell_pkg.sv
// gru_pkg: shared Q4.4 fixed-point types, constants and arithmetic helpers
// for the GRU cell datapath.
//   q44_t      : signed Q4.4 operand (8 bit)
//   acc_t      : signed 12-bit accumulator holding Q4.4-scaled sums
//   act_mode_e : activation select for gru_hard_act
// Optional build macro: GRU_ROUND_EN (round half up on every >>>4 rescale,
// otherwise floor truncation).
package gru_pkg;

    typedef logic signed [7:0]  q44_t;
    typedef logic signed [11:0] acc_t;

    typedef enum logic {
        ACT_SIG  = 1'b0,
        ACT_TANH = 1'b1
    } act_mode_e;

    localparam int FRAC_BITS = 4;
    localparam int Q_ONE     = 16;
    localparam int Q_HALF    = 8;
    localparam int Q_MAX     = 127;
    localparam int Q_MIN     = -128;
    localparam int ACC_MAX   = 2047;
    localparam int ACC_MIN   = -2048;

    // Drop the extra fraction bits of a product or product sum.
    function automatic logic signed [23:0] rescale(input logic signed [23:0] v);
`ifdef GRU_ROUND_EN
        return (v + 24'sd8) >>> FRAC_BITS;
`else
        return v >>> FRAC_BITS;
`endif
    endfunction

    // Multiply and rescale. Callers only feed 8x8 or 5x12 bit operands,
    // so the rescaled result always fits the accumulator.
    function automatic acc_t qmul(input acc_t a, input acc_t b);
        logic signed [23:0] p;
        p = 24'(a) * 24'(b);
        return acc_t'(rescale(p));
    endfunction

    // Three-term sum clamped to the accumulator range instead of wrapping.
    function automatic acc_t add_sat(input acc_t a, input acc_t b, input acc_t c);
        logic signed [13:0] s;
        s = 14'(a) + 14'(b) + 14'(c);
        if (s > 14'(ACC_MAX))      return acc_t'(ACC_MAX);
        else if (s < 14'(ACC_MIN)) return acc_t'(ACC_MIN);
        else                       return acc_t'(s);
    endfunction

    function automatic q44_t sat8(input logic signed [23:0] v);
        if (v > 24'(Q_MAX))      return q44_t'(Q_MAX);
        else if (v < 24'(Q_MIN)) return q44_t'(Q_MIN);
        else                     return q44_t'(v);
    endfunction

endpackage

// File: rtl/gru_lstm_cell_hard_act.sv
// gru_hard_act: combinational piecewise-linear activation.
//   mode_i : ACT_SIG  -> clamp((v>>>2)+8, 0, 16)   (0.25v + 0.5)
//            ACT_TANH -> clamp(v, -16, 16)
//   v_i    : Q4.4-scaled accumulator input
//   y_o    : Q4.4 activation, always within [-16, 16]
module gru_hard_act
    import gru_pkg::*;
(
    input  act_mode_e mode_i,
    input  acc_t      v_i,
    output q44_t      y_o
);

    acc_t t;
    acc_t lo;
    acc_t y;

    always_comb begin
        t  = v_i;
        lo = acc_t'(-Q_ONE);
        if (mode_i == ACT_SIG) begin
            // v_i >= -2048, so the offset add cannot overflow.
            t  = (v_i >>> 2) + acc_t'(Q_HALF);
            lo = '0;
        end
        if (t < lo)                  y = lo;
        else if (t > acc_t'(Q_ONE))  y = acc_t'(Q_ONE);
        else                         y = t;
        y_o = q44_t'(y);
    end

endmodule

// File: rtl/gru_lstm_cell.sv
// gru_lstm_cell: single-unit GRU cell, signed Q4.4, hard sigmoid/tanh gates.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset, clears the whole pipeline
//   in_valid  : X / h_in valid this cycle
//   X, h_in   : Q4.4 input sample and previous hidden state
//   out_valid : one-cycle pulse per accepted input, 3 edges after sampling
//   h_out     : Q4.4 new hidden state, held between pulses
// Optional build macro: GRU_ROUND_EN (round half up instead of truncate).
// Pipeline: s1 gates z/r, s2 candidate n, s3 full-width blend sum,
// then rescale + saturate into the output register.
module gru_lstm_cell
    import gru_pkg::*;
#(
    parameter q44_t WZ = 8'sd16,
    parameter q44_t UZ = 8'sd16,
    parameter q44_t BZ = 8'sd0,
    parameter q44_t WR = 8'sd16,
    parameter q44_t UR = 8'sd16,
    parameter q44_t BR = 8'sd0,
    parameter q44_t WN = 8'sd16,
    parameter q44_t UN = 8'sd16,
    parameter q44_t BN = 8'sd0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic signed [7:0] X,
    input  logic signed [7:0] h_in,
    output logic              out_valid,
    output logic signed [7:0] h_out
);

    localparam int STAGES = 4;

    logic [STAGES:1] vld_q;

    // stage 1
    acc_t zp_d, rp_d, uh_d, xn_d;
    q44_t z_d, r_d;
    q44_t z1_q, r1_q, h1_q;
    acc_t uh1_q, xn1_q;

    // stage 2
    acc_t np_d;
    q44_t n_d;
    q44_t n2_q, z2_q, h2_q;

    // stage 3 / output
    logic signed [15:0] omz_d, bl_d, bl3_q;
    q44_t h_out_d, h_out_q;

    always_comb begin
        zp_d = add_sat(qmul(acc_t'(WZ), acc_t'(X)), qmul(acc_t'(UZ), acc_t'(h_in)), acc_t'(BZ));
        rp_d = add_sat(qmul(acc_t'(WR), acc_t'(X)), qmul(acc_t'(UR), acc_t'(h_in)), acc_t'(BR));
        uh_d = qmul(acc_t'(UN), acc_t'(h_in));
        xn_d = qmul(acc_t'(WN), acc_t'(X));
    end

    gru_hard_act u_act_z (.mode_i(ACT_SIG),  .v_i(zp_d), .y_o(z_d));
    gru_hard_act u_act_r (.mode_i(ACT_SIG),  .v_i(rp_d), .y_o(r_d));

    always_comb begin
        np_d = add_sat(xn1_q, qmul(acc_t'(r1_q), uh1_q), acc_t'(BN));
    end

    gru_hard_act u_act_n (.mode_i(ACT_TANH), .v_i(np_d), .y_o(n_d));

    // Blend (16-z)*n + z*h; |result| <= 16*128, so 16 bits is exact.
    always_comb begin
        omz_d   = 16'(Q_ONE) - 16'(z2_q);
        bl_d    = omz_d * 16'(n2_q) + 16'(z2_q) * 16'(h2_q);
        h_out_d = sat8(rescale(24'(bl3_q)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            z1_q    <= '0;
            r1_q    <= '0;
            h1_q    <= '0;
            uh1_q   <= '0;
            xn1_q   <= '0;
            n2_q    <= '0;
            z2_q    <= '0;
            h2_q    <= '0;
            bl3_q   <= '0;
            h_out_q <= '0;
        end else begin
            vld_q <= {vld_q[STAGES-1:1], in_valid};
            if (in_valid) begin
                z1_q  <= z_d;
                r1_q  <= r_d;
                h1_q  <= h_in;
                uh1_q <= uh_d;
                xn1_q <= xn_d;
            end
            if (vld_q[1]) begin
                n2_q <= n_d;
                z2_q <= z1_q;
                h2_q <= h1_q;
            end
            if (vld_q[2]) bl3_q   <= bl_d;
            if (vld_q[3]) h_out_q <= h_out_d;
        end
    end

    assign out_valid = vld_q[STAGES];
    assign h_out     = h_out_q;

endmodule

// File: tb/tb_gru_lstm_cell.sv
module tb_gru_lstm_cell;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] X = '0;
    logic signed [7:0] h_in = '0;
    logic              out_valid;
    logic signed [7:0] h_out;

    always #5 clk = ~clk;

    gru_lstm_cell dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .X        (X),
        .h_in     (h_in),
        .out_valid(out_valid),
        .h_out    (h_out)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_h  = 0;

    typedef struct { int due; int val; } exp_t;
    exp_t expq[$];
    int   obs[$];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: floor division and clamps on plain integers, weights 1.0, biases 0.
    function automatic int fdiv(input int v, input int d);
        int q;
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int model(input int x, input int h);
        int zp, rp, z, r, np, n;
        zp = clampi(fdiv(16 * x, 16) + fdiv(16 * h, 16) + 0, -2048, 2047);
        rp = clampi(fdiv(16 * x, 16) + fdiv(16 * h, 16) + 0, -2048, 2047);
        z  = clampi(fdiv(zp, 4) + 8, 0, 16);
        r  = clampi(fdiv(rp, 4) + 8, 0, 16);
        np = clampi(fdiv(16 * x, 16) + fdiv(r * fdiv(16 * h, 16), 16) + 0, -2048, 2047);
        n  = clampi(np, -16, 16);
        return clampi(fdiv((16 - z) * n + z * h, 16), -128, 127);
    endfunction

    // Accepted samples become expected outputs 3 edges later; reset flushes them.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            expq.delete();
            exp_h = 0;
        end else if (in_valid) begin
            expq.push_back('{due: cyc + 3, val: model(int'(X), int'(h_in))});
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (cyc > 0) begin
            ev = (expq.size() > 0) && (expq[0].due == cyc);
            if (ev) begin
                exp_h = expq[0].val;
                void'(expq.pop_front());
            end
            chk("out_valid", 32'(out_valid), ev ? 32'sd1 : 32'sd0);
            chk("h_out", 32'(h_out), 32'(exp_h));
            if (out_valid === 1'b1) obs.push_back(int'(h_out));
        end
    end

    task automatic drive(input int x, input int h, input bit v);
        @(negedge clk);
        X        = 8'(x);
        h_in     = 8'(h);
        in_valid = v;
    endtask

    function automatic int pick();
        int k;
        k = int'($urandom_range(0, 7));
        case (k)
            0: return -128;
            1: return 127;
            2: return 0;
            3: return 16;
            default: return int'($signed(8'($urandom_range(0, 255))));
        endcase
    endfunction

    int vx[4] = '{-128, 16, -16, 1};
    int vh[4] = '{-128, 17, 17, 0};
    int vo[4] = '{-16, 17, 4, 0};

    initial begin
        // Reset held for two edges while in_valid is high.
        rst_n = 1'b0; in_valid = 1'b1; X = 8'sd16; h_in = 8'sd17;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

        // Pin the model against hand-computed values.
        for (int i = 0; i < 4; i++) chk($sformatf("model_vec%0d", i), 32'(model(vx[i], vh[i])), 32'(vo[i]));
        chk("model_sat_hi", 32'(model(127, 127)), 32'sd127);

        // Single extreme-operand vector.
        obs.delete();
        drive(-128, -128, 1'b1);
        drive(0, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("single_count", 32'(obs.size()), 32'sd1);
        if (obs.size() == 1) chk("single_val", 32'(obs[0]), -32'sd16);

        // Back-to-back directed vectors.
        obs.delete();
        for (int i = 0; i < 4; i++) drive(vx[i], vh[i], 1'b1);
        drive(0, 0, 1'b0);
        repeat (6) @(negedge clk);
        chk("b2b_count", 32'(obs.size()), 32'sd4);
        for (int i = 0; i < 4; i++)
            if (i < obs.size()) chk($sformatf("b2b_val%0d", i), 32'(obs[i]), 32'(vo[i]));

        // Same vectors, then reset while they are still in flight.
        for (int i = 0; i < 4; i++) drive(vx[i], vh[i], 1'b1);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        obs.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("flush_no_valid", 32'(obs.size()), 32'sd0);

        // Randomized traffic with bubbles and occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 79) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            X        = 8'(pick());
            h_in     = 8'(pick());
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("drain_empty", 32'(expq.size()), 32'sd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
